contador_sinc_param: RTL
========================

// Module: contador_sinc_param
// PURPOSE
//  Parametrised, fully synchronous multi-mode up/down counter: the next generation of the 4-bit MODO counter.
//  Built as NUM_ETAPAS cascaded stages of ETAPA_W bits each. All stages share one CLK, with no ripple clocks.
//  Each stage has a wrap flag, plus one registered wrap flag for the whole counter.
//  Used as the datapath/timer counter wherever a >4-bit MODO-controlled count is required.
// PARAMETERS
//  ETAPA_W     4  bits per stage (>=2)
//  NUM_ETAPAS  4  number of stages; total width W = ETAPA_W*NUM_ETAPAS
//  PASO        3  decrement amount in MODO=10; legal range 1..(2**ETAPA_W)-1
// PORTS
//  CLK        in   1              rising-edge clock, sole clock
//  RESET_N    in   1              synchronous reset, active-low
//  ENB        in   1              count/load enable
//  MODO       in   2              00 up+1, 01 down-1, 10 down-PASO, 11 parallel load
//  D          in   W              parallel load value (MODO=11)
//  Q          out  W              counter value (registered)
//  RCO        out  1              registered full-width wrap flag
//  RCO_ETAPA  out  NUM_ETAPAS     registered per-stage wrap flags; bit i = stage i
// BEHAVIOUR
//  - Reset: RESET_N=0 at a CLK edge sets Q=0, RCO=0 and RCO_ETAPA=0. Reset has priority over ENB and MODO,
//    and applies mid-count or mid-pulse.
//  - All outputs are registered. Q, RCO and RCO_ETAPA update on the same edge.
//    RCO=1 in the same cycle that Q shows the wrapped value.
//  - ENB=0: Q holds. RCO and RCO_ETAPA clear to 0, so a wrap pulse never stretches beyond one enabled cycle.
//  - MODO is sampled every edge. A mode change takes effect on the next edge; there is no pipeline and no drain.
//  - MODO=00: Q <= (Q+1) mod 2**W. RCO <= (Q == all ones).
//      Stage i increments iff ENB and stages 0..i-1 are all at all-ones (synchronous carry chain).
//      RCO_ETAPA[i] <= stage i is at all-ones and receives carry-in.
//  - MODO=01: Q <= (Q-1) mod 2**W. RCO <= (Q == 0).
//      Stage i decrements iff stages 0..i-1 are all 0.
//      RCO_ETAPA[i] <= stage i is at 0 and receives borrow-in.
//  - MODO=10: Q <= (Q-PASO) mod 2**W. RCO <= (Q < PASO).
//      Stage 0 subtracts PASO and borrows iff Q[ETAPA_W-1:0] < PASO.
//      Each stage i>0 subtracts its borrow-in and borrows out iff it is at 0 and has borrow-in.
//      RCO_ETAPA[i] <= borrow-out of stage i.
//  - MODO=11: Q <= D. RCO <= 0 and RCO_ETAPA <= 0 (a load is never a wrap).
//  - Arithmetic is unsigned and modulo 2**W. Carry and borrow are combinational within one cycle.
//    There is no saturation.
//  - RCO equals the AND-reduction of the carry/borrow chain up to the top stage.
//    This is consistent with RCO_ETAPA[NUM_ETAPAS-1].
//  - No X may propagate from reset. The register inits are not relied on.
// STRUCTURE
//  - Shared include contador_defs.vh holds MODO codes:
//    MODO_ARRIBA=2'b00, MODO_ABAJO=2'b01, MODO_PASO=2'b10, MODO_CARGA=2'b11.
//  - Sub-module contador_etapa, instanced NUM_ETAPAS times via generate.
//      Parameters: ETAPA_W, PASO_ETAPA (PASO for stage 0, 1 for the others).
//      Ports: CLK, RESET_N, ENB, MODO, D slice, ci (carry/borrow in), Q slice, co (combinational carry/borrow out),
//      RCO_ETAPA bit.
//      Stage 0 has ci=1. Stage i has ci = co of stage i-1.
//  - Top level: chain wiring, plus the RCO register = co of the top stage, gated by ENB and MODO!=11.
// TESTING (defaults ETAPA_W=4, NUM_ETAPAS=4, PASO=3, W=16)
//  1. Q=0x1234, ENB=1, MODO=00, RESET_N=0 for one edge -> Q=0x0000, RCO=0, RCO_ETAPA=4'b0000.
//     Release -> Q=0x0001.
//  2. Load 0xFFFE, then MODO=00 -> Q=0xFFFF, RCO=0.
//     Next edge Q=0x0000, RCO=1, RCO_ETAPA=4'b1111. Next edge Q=0x0001, RCO=0.
//  3. Q=0x00FF, MODO=00 -> Q=0x0100, RCO_ETAPA=4'b0011, RCO=0.
//     MODO=01 from 0x0100 -> Q=0x00FF, RCO_ETAPA=4'b0011.
//  4. Q=0x0004, MODO=10 -> Q=0x0001, RCO=0.
//     Next edge Q=0xFFFE, RCO=1, RCO_ETAPA=4'b1111.
//     Next edge Q=0xFFFB, RCO=0, RCO_ETAPA=4'b0000.
//  5. Mid-count at Q=0x0040: ENB=0 for 3 cycles -> Q=0x0040 held, RCO=0.
//     Then MODO=11, D=0xA5C3, ENB=1 -> Q=0xA5C3, RCO=0.
//  6. At Q=0x0000 with RCO=1 (just wrapped up), RESET_N=0 -> next edge Q=0, RCO=0.
//     Also run a parameter sweep with ETAPA_W=3, NUM_ETAPAS=2, PASO=5, checked against a modulo-64 reference model.

Source files
------------

// File: rtl/contador_sinc_param_pkg.sv
// Shared MODO encoding for the multi-stage synchronous counter and its stages.
// Kept in one package so every stage and the top decode modes identically.
package contador_sinc_param_pkg;

    typedef enum logic [1:0] {
        MODO_ARRIBA = 2'b00,
        MODO_ABAJO  = 2'b01,
        MODO_PASO   = 2'b10,
        MODO_CARGA  = 2'b11
    } modo_e;

    function automatic logic es_carga(input logic [1:0] modo);
        return modo == MODO_CARGA;
    endfunction

endpackage

// File: rtl/contador_sinc_param_etapa.sv
// One ETAPA_W-bit slice of the counter: adds/subtracts its carry/borrow-in and
// exposes a combinational carry/borrow-out so the whole chain settles in one cycle.
module contador_etapa
    import contador_sinc_param_pkg::*;
#(
    parameter int ETAPA_W    = 4,
    parameter int PASO_ETAPA = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               ENB,
    input  logic [1:0]         MODO,
    input  logic [ETAPA_W-1:0] D,
    input  logic               ci,
    output logic [ETAPA_W-1:0] Q,
    output logic               co,
    output logic               RCO_ETAPA
);

    localparam logic [ETAPA_W-1:0] PASO_L = ETAPA_W'(PASO_ETAPA);
    localparam logic [ETAPA_W-1:0] UNO    = ETAPA_W'(1);

    modo_e              w_modo;
    logic [ETAPA_W-1:0] w_resta;
    logic [ETAPA_W-1:0] w_q_sig;
    logic               w_co;

    logic [ETAPA_W-1:0] r_q;
    logic               r_rco;

    assign w_modo = modo_e'(MODO);

    // Only MODO_PASO uses the stage step; plain down-count always borrows by one.
    assign w_resta = (w_modo == MODO_PASO) ? PASO_L : UNO;

    always_comb begin
        w_q_sig = r_q;
        w_co    = 1'b0;
        case (w_modo)
            MODO_ARRIBA: begin
                w_co = ci && (r_q == '1);
                if (ci) begin
                    w_q_sig = r_q + UNO;
                end
            end
            MODO_ABAJO, MODO_PASO: begin
                w_co = ci && (r_q < w_resta);
                if (ci) begin
                    w_q_sig = r_q - w_resta;
                end
            end
            default: begin
                w_q_sig = D;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_q   <= '0;
            r_rco <= 1'b0;
        end else if (ENB) begin
            r_q   <= w_q_sig;
            r_rco <= w_co;
        end else begin
            r_rco <= 1'b0;
        end
    end

    assign Q         = r_q;
    assign co        = w_co;
    assign RCO_ETAPA = r_rco;

endmodule

// File: rtl/contador_sinc_param.sv
// Fully synchronous multi-mode up/down counter built from NUM_ETAPAS cascaded stages.
// ENB qualifies every edge: with ENB=0 the value holds and the wrap flags drop to 0.
module contador_sinc_param
    import contador_sinc_param_pkg::*;
#(
    parameter int ETAPA_W    = 4,
    parameter int NUM_ETAPAS = 4,
    parameter int PASO       = 3,
    localparam int W         = ETAPA_W * NUM_ETAPAS
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ENB,
    input  logic [1:0]            MODO,
    input  logic [W-1:0]          D,
    output logic [W-1:0]          Q,
    output logic                  RCO,
    output logic [NUM_ETAPAS-1:0] RCO_ETAPA
);

    logic [NUM_ETAPAS:0]   w_carry;
    logic [W-1:0]          w_q;
    logic [NUM_ETAPAS-1:0] w_rco_etapa;
    logic                  r_rco;

    // Stage 0 always sees a carry/borrow-in; higher stages chain off the one below.
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < NUM_ETAPAS; g++) begin : g_etapa
        contador_etapa #(
            .ETAPA_W    (ETAPA_W),
            .PASO_ETAPA ((g == 0) ? PASO : 1)
        ) u_etapa (
            .CLK       (CLK),
            .RESET_N   (RESET_N),
            .ENB       (ENB),
            .MODO      (MODO),
            .D         (D[g*ETAPA_W +: ETAPA_W]),
            .ci        (w_carry[g]),
            .Q         (w_q[g*ETAPA_W +: ETAPA_W]),
            .co        (w_carry[g+1]),
            .RCO_ETAPA (w_rco_etapa[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_rco <= 1'b0;
        end else begin
            r_rco <= ENB && !es_carga(MODO) && w_carry[NUM_ETAPAS];
        end
    end

    assign Q         = w_q;
    assign RCO       = r_rco;
    assign RCO_ETAPA = w_rco_etapa;

endmodule
